// File: rtl/fetch_redirect.sv
// ============================================================================
// fetch_redirect : PC generation and single-outstanding instruction fetch with
//                  branch/jump redirect and stale-response discard.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fetch_redirect #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        misaligned_o
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_req_pc;
    logic [31:0] w_req_pc_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        r_instr_valid;
    logic        w_instr_valid_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_instr_pc;
    logic [31:0] w_instr_pc_nxt;
    logic        r_misaligned;
    logic        w_misaligned_nxt;

    logic        w_req_valid;
    logic        w_handshake;
    logic        w_rsp;
    logic [31:0] w_redirect_pc;

    // Issue only when the output register is empty or drains this cycle, so a
    // response can never find it full.
    assign w_req_valid   = (r_state == S_REQ) && !rst_i && (!r_instr_valid || instr_ready_i);
    assign w_handshake   = w_req_valid && imem_req_ready_i;
    assign w_rsp         = (r_state == S_WAIT) && imem_rsp_valid_i;
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_req_pc_nxt      = r_req_pc;
        w_kill_nxt        = r_kill;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_misaligned_nxt  = 1'b0;

        if (r_instr_valid && instr_ready_i) begin
            w_instr_valid_nxt = 1'b0;
            w_instr_nxt       = NOP_INSTR;
        end

        case (r_state)
            S_REQ: begin
                if (w_handshake) begin
                    w_req_pc_nxt = r_pc;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rsp) begin
                    w_state_nxt = S_REQ;
                    if (r_kill) begin
                        w_kill_nxt = 1'b0;
                    end else begin
                        w_instr_nxt       = imem_rsp_data_i;
                        w_instr_pc_nxt    = r_req_pc;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_nxt          = r_req_pc + 32'd4;
                    end
                end
            end
            default: w_state_nxt = S_REQ;
        endcase

        // Redirect overrides every update above, including a same-cycle fill.
        if (redirect_i) begin
            w_pc_nxt          = w_redirect_pc;
            w_instr_valid_nxt = 1'b0;
            w_instr_nxt       = NOP_INSTR;
            w_instr_pc_nxt    = r_instr_pc;
            w_misaligned_nxt  = (redirect_pc_i[1:0] != 2'b00);
            if (r_state == S_REQ) begin
                w_kill_nxt = w_handshake;
            end else if (w_rsp) begin
                w_kill_nxt = 1'b0;
            end else begin
                w_kill_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_REQ;
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_req_pc      <= {RESET_PC[31:2], 2'b00};
            r_kill        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_req_pc      <= w_req_pc_nxt;
            r_kill        <= w_kill_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_misaligned  <= w_misaligned_nxt;
        end
    end

    assign imem_req_valid_o = w_req_valid;
    assign imem_addr_o      = r_pc;
    assign instr_valid_o    = r_instr_valid;
    assign instr_o          = r_instr;
    assign instr_pc_o       = r_instr_pc;
    assign misaligned_o     = r_misaligned;

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect.sv
// ============================================================================
// tb_fetch_redirect : directed scenarios plus randomized redirect/backpressure
//                     traffic checked against a program-order stream model.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_redirect;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_ready;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misaligned;

    fetch_redirect #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (req_ready),
        .imem_addr_o      (imem_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .misaligned_o     (misaligned)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // memory responder state
    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr = 32'h0;
    int          lat  = 1;

    // pre-edge snapshots
    logic        s_req_valid, s_hs, s_rsp, s_iv, s_mis;
    logic [31:0] s_addr, s_instr, s_ipc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BD1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic redir, input logic [31:0] tgt);
        @(negedge clk);
        rsp_valid   = pend && (cnt == 0);
        rsp_data    = mem(paddr);
        redirect    = redir;
        redirect_pc = tgt;
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_addr;
        s_hs        = imem_req_valid && req_ready;
        s_rsp       = rsp_valid;
        s_iv        = instr_valid;
        s_instr     = instr;
        s_ipc       = instr_pc;
        s_mis       = misaligned;
        @(posedge clk);
        #1;
        redirect  = 1'b0;
        rsp_valid = 1'b0;
        if (s_rsp) pend = 1'b0;
        else if (pend && cnt > 0) cnt--;
        if (s_hs) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = s_addr;
        end
    endtask

    initial begin
        logic [31:0] exp_next;
        logic [31:0] tgt;
        logic [31:0] hold_addr;
        logic        hold_pending;
        logic        r;
        int          idle;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_data = 32'h0; instr_ready = 1'b1;

        // reset state
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        chk("rst_req_valid", s_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misaligned", misaligned, 0);

        // sequential fetch, 1-cycle memory
        rst = 1'b0; lat = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0);
            chk("seq_req_valid", s_req_valid, 1);
            chk("seq_req_addr", s_addr, 32'(4 * i));
            chk("seq_not_yet_valid", instr_valid, 0);
            cyc(1'b0, 32'h0);
            chk("seq_valid", instr_valid, 1);
            chk("seq_instr_pc", instr_pc, 32'(4 * i));
            chk("seq_instr", instr, mem(32'(4 * i)));
        end

        // decode stall holds the register and blocks fetch
        instr_ready = 1'b0;
        repeat (4) begin
            cyc(1'b0, 32'h0);
            chk("stall_req_valid", s_req_valid, 0);
            chk("stall_instr_pc", instr_pc, 32'h8);
            chk("stall_instr", instr, mem(32'h8));
        end
        instr_ready = 1'b1; lat = 4;
        cyc(1'b0, 32'h0);
        chk("release_req_valid", s_req_valid, 1);
        chk("release_req_addr", s_addr, 32'hC);

        // redirect during WAIT, response 3 cycles later is dropped
        lat = 1;
        cyc(1'b1, 32'h100);
        chk("rdw_instr_valid", instr_valid, 0);
        chk("rdw_misaligned", misaligned, 0);
        repeat (2) begin
            cyc(1'b0, 32'h0);
            chk("rdw_wait_req_valid", s_req_valid, 0);
        end
        cyc(1'b0, 32'h0);
        chk("rdw_dropped_valid", instr_valid, 0);
        cyc(1'b0, 32'h0);
        chk("rdw_new_req_valid", s_req_valid, 1);
        chk("rdw_new_req_addr", s_addr, 32'h100);
        cyc(1'b0, 32'h0);
        chk("rdw_new_valid", instr_valid, 1);
        chk("rdw_new_pc", instr_pc, 32'h100);
        chk("rdw_new_instr", instr, mem(32'h100));

        // redirect on the response cycle
        cyc(1'b0, 32'h0);
        chk("rrsp_req_addr", s_addr, 32'h104);
        cyc(1'b1, 32'h200);
        chk("rrsp_flushed_valid", instr_valid, 0);
        chk("rrsp_flushed_instr", instr, NOP);
        cyc(1'b0, 32'h0);
        chk("rrsp_req_valid", s_req_valid, 1);
        chk("rrsp_req_addr2", s_addr, 32'h200);
        cyc(1'b0, 32'h0);
        chk("rrsp_valid", instr_valid, 1);
        chk("rrsp_pc", instr_pc, 32'h200);

        // misaligned redirect with a buffered instr and a same-cycle handshake
        cyc(1'b1, 32'h103);
        chk("mis_hs_same_cycle", s_hs, 1);
        chk("mis_flush_valid", instr_valid, 0);
        chk("mis_flush_instr", instr, NOP);
        chk("mis_pulse", misaligned, 1);
        cyc(1'b0, 32'h0);
        chk("mis_pulse_held", s_mis, 1);
        chk("mis_pulse_end", misaligned, 0);
        chk("mis_stale_dropped", instr_valid, 0);
        cyc(1'b0, 32'h0);
        chk("mis_req_addr", s_addr, 32'h100);
        cyc(1'b0, 32'h0);
        chk("mis_valid", instr_valid, 1);
        chk("mis_pc", instr_pc, 32'h100);

        // reset in WAIT, response arrives the cycle after
        lat = 2;
        cyc(1'b0, 32'h0);
        chk("rstw_req_addr", s_addr, 32'h104);
        rst = 1'b1;
        cyc(1'b0, 32'h0);
        chk("rstw_valid", instr_valid, 0);
        rst = 1'b0; lat = 1;
        cyc(1'b0, 32'h0);
        chk("rstw_req_valid", s_req_valid, 1);
        chk("rstw_req_addr0", s_addr, 32'h0);
        chk("rstw_rsp_ignored", instr_valid, 0);
        cyc(1'b0, 32'h0);
        chk("rstw_first_valid", instr_valid, 1);
        chk("rstw_first_pc", instr_pc, 32'h0);

        // address wrap
        cyc(1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 32'h0);
        chk("wrap_stale_dropped", instr_valid, 0);
        cyc(1'b0, 32'h0);
        chk("wrap_req_top", s_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 32'h0);
        chk("wrap_top_pc", instr_pc, 32'hFFFF_FFFC);
        cyc(1'b0, 32'h0);
        chk("wrap_req_valid", s_req_valid, 1);
        chk("wrap_req_zero", s_addr, 32'h0);

        // randomized traffic against an in-order stream model
        exp_next = 32'h0; idle = 0; hold_pending = 1'b0; hold_addr = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            req_ready   = ($urandom_range(0, 2) != 0);
            lat         = $urandom_range(1, 4);
            r           = (n == 0) || ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else tgt = $urandom & 32'h0000_3FFF;
            cyc(r, tgt);
            if (n > 0) begin
                if (s_iv && instr_ready) begin
                    chk("rnd_pc", s_ipc, exp_next);
                    chk("rnd_instr", s_instr, mem(exp_next));
                    exp_next = exp_next + 32'd4;
                    idle = 0;
                end else begin
                    idle++;
                end
                if (!s_iv) chk("rnd_nop", s_instr, NOP);
                if (s_req_valid) chk("rnd_align", {30'h0, s_addr[1:0]}, 32'h0);
                if (hold_pending) begin
                    chk("rnd_hold_valid", s_req_valid, 1);
                    chk("rnd_hold_addr", s_addr, hold_addr);
                end
            end
            hold_pending = s_req_valid && !s_hs && !r;
            hold_addr    = s_addr;
            if (r) begin
                exp_next = {tgt[31:2], 2'b00};
                chk("rnd_redir_flush", instr_valid, 0);
                chk("rnd_redir_mis", misaligned, (tgt[1:0] != 2'b00));
            end else begin
                chk("rnd_mis_idle", misaligned, 0);
            end
            if (idle > 200) begin
                chk("rnd_progress_idle_cycles", idle, 0);
                break;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- PC generation and instruction-fetch sequencer for the nano_rv32i core.
- Sits upstream of decode and consumes the branch/jump redirect that the branch comparison and jump logic produce.
- Keeps one instruction-memory request in flight at a time and holds the fetched word in a single-entry output register.
- Discards stale fetch responses when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_o while no valid instruction is held (ADDI x0,x0,0).

Ports:
- clk_i  in  1  clock. One clock domain.
- rst_i  in  1  reset. Synchronous, active-high.
- redirect_i  in  1  taken branch or jump; single-cycle pulse.
- redirect_pc_i  in  32  redirect target.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_addr_o  out  32  fetch address; always word aligned.
- imem_rsp_valid_i  in  1  read data valid. No backpressure on this path.
- imem_rsp_data_i  in  32  instruction word.
- instr_valid_o  out  1  output register holds a valid instruction.
- instr_ready_i  in  1  decode consumes the instruction.
- instr_o  out  32  instruction word.
- instr_pc_o  out  32  PC of instr_o.
- misaligned_o  out  1  one-cycle pulse: the redirect target had bits [1:0] != 0.

Behaviour:
- Internal state: pc (next PC to fetch), req_pc, kill flag, FSM {REQ, WAIT}.
- Reset (rst_i=1 at a clock edge):
  - pc=RESET_PC, FSM=REQ, kill=0.
  - instr_valid_o=0, instr_o=NOP_INSTR, instr_pc_o=RESET_PC, misaligned_o=0.
  - imem_req_valid_o=0 while rst_i is high.
  - Instruction memory shares rst_i; any response arriving while the FSM is in REQ is ignored.
- REQ state:
  - imem_req_valid_o = !instr_valid_o || instr_ready_i (output register empty or draining this cycle).
  - imem_addr_o = pc.
  - On handshake (valid && ready): req_pc <= pc, go to WAIT.
  - imem_req_valid_o and imem_addr_o must stay stable until the handshake, unless a redirect occurs.
- WAIT state:
  - imem_req_valid_o=0.
  - On imem_rsp_valid_i with kill=0: instr_o <= data, instr_pc_o <= req_pc, instr_valid_o <= 1, pc <= req_pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), go to REQ.
  - On imem_rsp_valid_i with kill=1: drop the data, kill <= 0, go to REQ.
- Output register:
  - Drains when instr_valid_o && instr_ready_i: instr_valid_o <= 0, instr_o <= NOP_INSTR, unless it is refilled in the same cycle.
  - A one-outstanding request plus the issue rule guarantees a response never finds the register full.
- Latency and throughput:
  - Request handshake at cycle N, response at N+k (k>=1), instr_valid_o at N+k+1.
  - Peak rate: one instruction per 2 cycles.
- Redirect (redirect_i=1) has top priority over all other updates:
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - instr_valid_o <= 0 and instr_o <= NOP_INSTR, even if instr_ready_i is high.
  - misaligned_o <= (redirect_pc_i[1:0] != 0) for exactly one cycle.
  - In REQ without a handshake: stay in REQ; next cycle requests the new pc.
  - In REQ with a handshake in the same cycle: go to WAIT with kill=1 (the old-address request is in flight).
  - In WAIT with no response this cycle: kill <= 1.
  - In WAIT with a response in the same cycle: discard the response, go to REQ, kill <= 0.
- Back-to-back redirects: the last one wins; kill remains set until exactly one response is dropped.
- imem_addr_o is always 4-byte aligned.

Test Plan:
- Reset release, imem ready=1, 1-cycle latency, instr_ready_i=1 -> requests at 0x0, 0x4, 0x8. instr_pc_o sequence 0x0, 0x4, 0x8, each instr_valid_o one response-cycle later. instr_o matches memory.
- Hold instr_ready_i=0 with an instruction buffered -> imem_req_valid_o stays 0, instr_o/instr_pc_o stable. Release -> next request at instr_pc_o+4.
- Redirect to 0x100 while in WAIT, response 3 cycles later -> that response dropped, instr_valid_o stays 0. Next request address 0x100, next instr_pc_o=0x100.
- Redirect to 0x200 in the same cycle as the response -> response discarded, buffered instruction flushed. Next request 0x200, no extra drop.
- Redirect to 0x103 -> misaligned_o high for one cycle. Next fetch address 0x100.
- Assert rst_i mid-WAIT, with a response arriving the cycle after reset -> response ignored, instr_valid_o=0. First request 0x0; wrap check: fetch at 0xFFFF_FFFC followed by a request at 0x0.
